otter_decode_stage: RTL and testbench
=====================================

Name: otter_decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the OTTER RV32I core; generalised successor of the single-cycle combinational decoder.
- Accepts instruction and PC from fetch, decodes to the control bundle and holds it in a pipeline register for execute.
- Adds illegal-instruction detection, optional M-extension and CSR/MRET decode, interrupt takeover, stall and flush.
- Branch selection is resolved late from the registered branch type and execute-stage compare flags.

Parameters:
- XLEN, 32, PC width.
- EN_M, 0, decode MUL/DIV group (opcode 0110011, funct7=0000001); if 0 these are illegal.
- EN_CSR, 1, decode SYSTEM CSR ops and MRET, and enable interrupt takeover; if 0 all SYSTEM opcodes are illegal and intr is ignored.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_instr  out  32  registered instruction.
- br_eq, br_lt, br_ltu  in  1 each  execute compare flags for the held instruction.
- intr  in  1  external interrupt request, already masked by mie.
- alu_fun  out  5  bit4=M group, bits3:0 = existing ALU_FUN encoding.
- alu_srcA  out  2  0=rs1, 1=U-imm, 2=~rs1 (CSRRC).
- alu_srcB  out  3  0=rs2, 1=I-imm, 2=S-imm, 3=PC, 4=CSR.
- rf_wr_sel  out  2  0=CSR, 1=PC+4, 2=mem, 3=ALU.
- reg_wr, mem_wr, mem_rd  out  1 each  gated strobes.
- mem_size  out  2  funct3[1:0].
- mem_sign  out  1  ~funct3[2].
- csr_wr, mret, illegal, intr_taken  out  1 each.
- pc_source  out  3  0=PC+4, 1=JALR, 2=branch, 3=JAL, 4=mtvec, 5=mepc.

Behaviour:
- in_ready = ~out_valid | out_ready (combinational, no dependency on in_valid).
- Load: on the rising edge with in_valid & in_ready & ~flush, the register captures in_pc, in_instr and the decoded bundle; out_valid <= 1.
- Drain: out_ready & ~(in_valid & in_ready) & ~flush sets out_valid <= 0.
- Stall: out_valid & ~out_ready holds every registered field stable.
- Flush has priority: out_valid <= 0 next cycle and any same-cycle input is discarded.
- Latency: one cycle from accept to out_valid. Full throughput with out_ready held high.
- Reset: out_valid=0; registered instr=32'h00000013 (NOP); out_pc=0.
  - With RST high, all strobes are 0 and pc_source=0.
  - RST overrides flush and load.
- Decode table keeps the existing OTTER encodings for R, I, S, B, LOAD, LUI, AUIPC, JAL and JALR.
- New rules for R and I types:
  - R-type funct3=010 (SLT) yields ALU_FUN 0010.
  - IR30 selects SUB only for R-type funct3=000.
  - IR30 selects SRA/SRAI for funct3=101.
- Illegal is set when:
  - the opcode is not decoded;
  - LOAD funct3 is 011/110/111, or STORE funct3 is >010;
  - B funct3 is 010/011;
  - R-type funct7 is not 0000000/0100000 (or 0000001 when EN_M);
  - SYSTEM funct3 is 100 (when EN_CSR).
- When illegal=1: reg_wr=mem_wr=mem_rd=csr_wr=0, and pc_source=4 if EN_CSR, else 0.
- Output gating: all strobes and the non-zero pc_source are qualified by out_valid. When out_valid=0, everything reads 0.
- pc_source is combinational from the registered branch type and the live flags:
  - BEQ: eq.
  - BNE: ~eq.
  - BLT: lt.
  - BGE: ~lt.
  - BLTU: ltu.
  - BGEU: ~ltu.
  - Taken gives 2, not taken gives 0.
- MRET: mret=1, pc_source=5, no reg_wr.
- CSRRW/S/C: rf_wr_sel=0, csr_wr=1, reg_wr=(rd!=0).
- Interrupt (EN_CSR): intr & out_valid & ~illegal gives intr_taken=1 and pc_source=4, and forces reg_wr, mem_wr, mem_rd and csr_wr to 0. Interrupt has priority over branch, jump and MRET.
- reg_wr=0 whenever rd=x0.

Decomposition:
- Package otter_pkg holds:
  - opcode_t enum (R, I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM);
  - alu_fun_t, srcA_t, srcB_t, wr_sel_t, pc_src_t enums with the values above;
  - ctrl_t packed struct with all decoded fields;
  - NOP constant.
- One sub-module, otter_decode_comb: a pure combinational instr-to-ctrl_t decode, instantiated ahead of the register.

Test Plan:
- Reset: RST high 2 cycles with in_valid=1 -> out_valid=0, reg_wr=0, pc_source=0; first accept 1 cycle after RST drops.
- Stream: ADD x1,x2,x3 (0x003100B3), SUB (0x403100B3), SRAI (0x4020D093) with out_ready=1 -> alu_fun 00000/01000/01101 on consecutive cycles, rf_wr_sel=3.
- Branch: BGE (funct3=101) held, flags lt=1 then lt=0 -> pc_source 0 then 2 without a new accept.
- Backpressure and flush: out_ready=0 for 3 cycles -> in_ready=0 and out_instr stable; flush pulse -> out_valid=0 next cycle and the concurrent input is dropped.
- Illegal and M: instr 0x02208033 with EN_M=0 -> illegal=1, reg_wr=0, pc_source=4; with EN_M=1 -> alu_fun[4]=1, illegal=0.
- Interrupt: intr=1 over a held SW -> intr_taken=1, mem_wr=0, pc_source=4; MRET (0x30200073) -> mret=1, pc_source=5.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types for the OTTER decode stage: opcodes, control-field encodings
// and the packed control bundle carried in the decode pipeline register.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  // bit4 flags the M group; bits 3:0 keep the classic OTTER ALU encoding
  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_LUI  = 5'b01001,
    ALU_SRA  = 5'b01101
  } alu_fun_t;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_UIMM = 2'd1,
    SRCA_NRS1 = 2'd2
  } srcA_t;

  typedef enum logic [2:0] {
    SRCB_RS2  = 3'd0,
    SRCB_IIMM = 3'd1,
    SRCB_SIMM = 3'd2,
    SRCB_PC   = 3'd3,
    SRCB_CSR  = 3'd4
  } srcB_t;

  typedef enum logic [1:0] {
    WR_CSR = 2'd0,
    WR_PC4 = 2'd1,
    WR_MEM = 2'd2,
    WR_ALU = 2'd3
  } wr_sel_t;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_src_t;

  typedef struct packed {
    alu_fun_t    alu_fun;
    srcA_t       alu_srcA;
    srcB_t       alu_srcB;
    wr_sel_t     rf_wr_sel;
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic        csr_wr;
    logic        mret;
    logic        illegal;
    logic        is_branch;
    pc_src_t     pc_src;
  } ctrl_t;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] MRET_INSTR = 32'h3020_0073;

endpackage

// File: rtl/otter_decode_comb.sv
// Pure combinational RV32I(+M, +CSR/MRET) instruction decode into ctrl_t.
// Strobes are already cleaned for illegal encodings and rd=x0 here.
module otter_decode_comb
  import otter_pkg::*;
#(
  parameter int EN_M   = 0,
  parameter int EN_CSR = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;
  logic       wr;
  logic       ill;
  ctrl_t      c;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd_nz  = |instr[11:7];

  always_comb begin
    c           = '0;
    wr          = 1'b0;
    ill         = 1'b0;
    c.alu_fun   = ALU_ADD;
    c.alu_srcA  = SRCA_RS1;
    c.alu_srcB  = SRCB_RS2;
    c.rf_wr_sel = WR_CSR;
    c.pc_src    = PC_PLUS4;
    c.mem_size  = funct3[1:0];
    c.mem_sign  = ~funct3[2];

    case (opcode_t'(instr[6:0]))
      OP_R: begin
        c.rf_wr_sel = WR_ALU;
        wr          = 1'b1;
        if (funct7 == 7'b0000001 && EN_M != 0)
          c.alu_fun = alu_fun_t'({2'b10, funct3});
        else if (funct7 == 7'b0000000 || funct7 == 7'b0100000)
          // IR30 only matters for ADD/SUB and SRL/SRA
          c.alu_fun = alu_fun_t'({1'b0, instr[30] & (funct3 == 3'b000 || funct3 == 3'b101), funct3});
        else
          ill = 1'b1;
      end
      OP_I: begin
        c.alu_srcB  = SRCB_IIMM;
        c.rf_wr_sel = WR_ALU;
        wr          = 1'b1;
        c.alu_fun   = alu_fun_t'({1'b0, instr[30] & (funct3 == 3'b101), funct3});
      end
      OP_LOAD: begin
        c.alu_srcB  = SRCB_IIMM;
        c.rf_wr_sel = WR_MEM;
        c.mem_rd    = 1'b1;
        wr          = 1'b1;
        ill         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        c.alu_srcB = SRCB_SIMM;
        c.mem_wr   = 1'b1;
        ill        = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        c.is_branch = 1'b1;
        ill         = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI: begin
        c.alu_fun   = ALU_LUI;
        c.alu_srcA  = SRCA_UIMM;
        c.rf_wr_sel = WR_ALU;
        wr          = 1'b1;
      end
      OP_AUIPC: begin
        c.alu_srcA  = SRCA_UIMM;
        c.alu_srcB  = SRCB_PC;
        c.rf_wr_sel = WR_ALU;
        wr          = 1'b1;
      end
      OP_JAL: begin
        c.rf_wr_sel = WR_PC4;
        c.pc_src    = PC_JAL;
        wr          = 1'b1;
      end
      OP_JALR: begin
        c.alu_srcB  = SRCB_IIMM;
        c.rf_wr_sel = WR_PC4;
        c.pc_src    = PC_JALR;
        wr          = 1'b1;
      end
      OP_SYSTEM: begin
        if (EN_CSR == 0) begin
          ill = 1'b1;
        end else if (funct3 == 3'b000) begin
          if (instr == MRET_INSTR) begin
            c.mret   = 1'b1;
            c.pc_src = PC_MEPC;
          end else begin
            ill = 1'b1;
          end
        end else if (funct3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          // CSRRW copies rs1, CSRRS ORs it in, CSRRC ANDs with ~rs1
          c.alu_srcB  = SRCB_CSR;
          c.rf_wr_sel = WR_CSR;
          c.csr_wr    = 1'b1;
          wr          = 1'b1;
          case (funct3[1:0])
            2'b01:   c.alu_fun = ALU_LUI;
            2'b10:   c.alu_fun = ALU_OR;
            default: begin
              c.alu_fun  = ALU_AND;
              c.alu_srcA = SRCA_NRS1;
            end
          endcase
        end
      end
      default: ill = 1'b1;
    endcase

    c.illegal = ill;
    c.reg_wr  = wr & rd_nz & ~ill;
    if (ill) begin
      c.mem_wr    = 1'b0;
      c.mem_rd    = 1'b0;
      c.csr_wr    = 1'b0;
      c.mret      = 1'b0;
      c.is_branch = 1'b0;
      c.pc_src    = (EN_CSR != 0) ? PC_MTVEC : PC_PLUS4;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/otter_decode_stage.sv
// Registered, valid/ready decode stage: decodes in front of a one-entry pipeline
// register, then resolves branches, interrupts and output gating on the way out.
module otter_decode_stage
  import otter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_M   = 0,
  parameter int EN_CSR = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic            br_ltu,
  input  logic            intr,
  output logic [4:0]      alu_fun,
  output logic [1:0]      alu_srcA,
  output logic [2:0]      alu_srcB,
  output logic [1:0]      rf_wr_sel,
  output logic            reg_wr,
  output logic            mem_wr,
  output logic            mem_rd,
  output logic [1:0]      mem_size,
  output logic            mem_sign,
  output logic            csr_wr,
  output logic            mret,
  output logic            illegal,
  output logic            intr_taken,
  output logic [2:0]      pc_source
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; ready never looks at valid, and flush discards both sides that cycle.
  ctrl_t            dec;
  ctrl_t            ctrl_q;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic             load;
  logic             act;
  logic             take;
  logic             br_taken;

  otter_decode_comb #(
    .EN_M   (EN_M),
    .EN_CSR (EN_CSR)
  ) u_decode (
    .instr (in_instr),
    .ctrl  (dec)
  );

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc_q    <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
      ctrl_q  <= dec;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

  assign act  = valid_q & ~RST;
  assign take = (EN_CSR != 0) & intr & act & ~ctrl_q.illegal;

  always_comb begin
    case (instr_q[14:12])
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = ~br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = ~br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = ~br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_fun    = '0;
    alu_srcA   = '0;
    alu_srcB   = '0;
    rf_wr_sel  = '0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_size   = '0;
    mem_sign   = 1'b0;
    csr_wr     = 1'b0;
    mret       = 1'b0;
    illegal    = 1'b0;
    intr_taken = 1'b0;
    pc_source  = PC_PLUS4;
    if (act) begin
      alu_fun    = ctrl_q.alu_fun;
      alu_srcA   = ctrl_q.alu_srcA;
      alu_srcB   = ctrl_q.alu_srcB;
      rf_wr_sel  = ctrl_q.rf_wr_sel;
      mem_size   = ctrl_q.mem_size;
      mem_sign   = ctrl_q.mem_sign;
      illegal    = ctrl_q.illegal;
      // an interrupt takes over the held instruction and suppresses its side effects
      reg_wr     = ctrl_q.reg_wr & ~take;
      mem_wr     = ctrl_q.mem_wr & ~take;
      mem_rd     = ctrl_q.mem_rd & ~take;
      csr_wr     = ctrl_q.csr_wr & ~take;
      mret       = ctrl_q.mret & ~take;
      intr_taken = take;
      if (take)
        pc_source = PC_MTVEC;
      else if (ctrl_q.is_branch)
        pc_source = br_taken ? PC_BRANCH : PC_PLUS4;
      else
        pc_source = ctrl_q.pc_src;
    end
  end

endmodule

// File: tb/tb_otter_decode_stage.sv
// Bench for otter_decode_stage: directed steps from the test plan followed by a
// randomized stream, all checked against a queue model and a rule-level decoder.
module tb_otter_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;
  logic        br_eq, br_lt, br_ltu, intr;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_pc0, out_instr0, out_pc1, out_instr1;
  logic [4:0]  alu_fun0, alu_fun1;
  logic [1:0]  srca0, srca1, wrsel0, wrsel1, msize0, msize1;
  logic [2:0]  srcb0, srcb1, pcs0, pcs1;
  logic        reg_wr0, mem_wr0, mem_rd0, msign0, csr_wr0, mret0, ill0, it0;
  logic        reg_wr1, mem_wr1, mem_rd1, msign1, csr_wr1, mret1, ill1, it1;
  logic [24:0] b0, b1;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_SRAI = 32'h4020D093;
  localparam logic [31:0] I_BGE  = 32'h0020D063;
  localparam logic [31:0] I_XOR  = 32'h003140B3;
  localparam logic [31:0] I_MUL  = 32'h02208033;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_MRET = 32'h30200073;

  always #5 clk = ~clk;

  otter_decode_stage #(.XLEN(32), .EN_M(0), .EN_CSR(1)) dut0 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_pc(out_pc0), .out_instr(out_instr0),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .intr(intr),
    .alu_fun(alu_fun0), .alu_srcA(srca0), .alu_srcB(srcb0), .rf_wr_sel(wrsel0),
    .reg_wr(reg_wr0), .mem_wr(mem_wr0), .mem_rd(mem_rd0), .mem_size(msize0),
    .mem_sign(msign0), .csr_wr(csr_wr0), .mret(mret0), .illegal(ill0),
    .intr_taken(it0), .pc_source(pcs0)
  );

  otter_decode_stage #(.XLEN(32), .EN_M(1), .EN_CSR(1)) dut1 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_pc(out_pc1), .out_instr(out_instr1),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .intr(intr),
    .alu_fun(alu_fun1), .alu_srcA(srca1), .alu_srcB(srcb1), .rf_wr_sel(wrsel1),
    .reg_wr(reg_wr1), .mem_wr(mem_wr1), .mem_rd(mem_rd1), .mem_size(msize1),
    .mem_sign(msign1), .csr_wr(csr_wr1), .mret(mret1), .illegal(ill1),
    .intr_taken(it1), .pc_source(pcs1)
  );

  assign b0 = {alu_fun0, srca0, srcb0, wrsel0, reg_wr0, mem_wr0, mem_rd0, msize0,
               msign0, csr_wr0, mret0, ill0, it0, pcs0};
  assign b1 = {alu_fun1, srca1, srcb1, wrsel1, reg_wr1, mem_wr1, mem_rd1, msize1,
               msign1, csr_wr1, mret1, ill1, it1, pcs1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected output bundle derived from the instruction-set rules.
  function automatic logic [24:0] model_bundle(input logic [31:0] ins, input bit en_m,
                                               input bit act, input bit eq, input bit lt,
                                               input bit ltu, input bit irq);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] alu;
    logic [1:0] sa, ws;
    logic [2:0] sb, pcs;
    bit rw, mw, mr, cw, mrt, ill, it, br, tk;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    alu = 0; sa = 0; sb = 0; ws = 0; pcs = 0;
    rw = 0; mw = 0; mr = 0; cw = 0; mrt = 0; ill = 0; it = 0; br = 0; tk = 0;
    if (!act) return '0;
    case (op)
      7'h33: begin
        ws = 3; rw = 1;
        if (f7 == 7'h01 && en_m) alu = 5'd16 + 5'(f3);
        else if (f7 == 7'h00) alu = 5'(f3);
        else if (f7 == 7'h20) alu = (f3 == 0 || f3 == 5) ? 5'd8 + 5'(f3) : 5'(f3);
        else ill = 1;
      end
      7'h13: begin sb = 1; ws = 3; rw = 1; alu = (f3 == 5 && ins[30]) ? 5'd13 : 5'(f3); end
      7'h03: begin sb = 1; ws = 2; rw = 1; mr = 1; ill = (f3 == 3 || f3 == 6 || f3 == 7); end
      7'h23: begin sb = 2; mw = 1; ill = (f3 > 2); end
      7'h63: begin br = 1; ill = (f3 == 2 || f3 == 3); end
      7'h37: begin alu = 9; sa = 1; ws = 3; rw = 1; end
      7'h17: begin sa = 1; sb = 3; ws = 3; rw = 1; end
      7'h6F: begin ws = 1; rw = 1; pcs = 3; end
      7'h67: begin sb = 1; ws = 1; rw = 1; pcs = 1; end
      7'h73: begin
        if (f3 == 0) begin
          if (ins == I_MRET) begin mrt = 1; pcs = 5; end
          else ill = 1;
        end else if (f3 == 4) ill = 1;
        else begin
          ws = 0; rw = 1; cw = 1; sb = 4;
          if (f3[1:0] == 1) alu = 9;
          else if (f3[1:0] == 2) alu = 6;
          else begin alu = 7; sa = 2; end
        end
      end
      default: ill = 1;
    endcase
    if (ins[11:7] == 0) rw = 0;
    if (ill) begin rw = 0; mw = 0; mr = 0; cw = 0; br = 0; pcs = 4; end
    if (br) begin
      case (f3)
        0: tk = eq;  1: tk = !eq;
        4: tk = lt;  5: tk = !lt;
        6: tk = ltu; 7: tk = !ltu;
        default: tk = 0;
      endcase
      pcs = tk ? 3'd2 : 3'd0;
    end
    if (irq && !ill) begin
      it = 1; pcs = 4; rw = 0; mw = 0; mr = 0; cw = 0; mrt = 0;
    end
    return {alu, sa, sb, ws, rw, mw, mr, f3[1:0], !f3[2], cw, mrt, ill, it, pcs};
  endfunction

  // Check all observable outputs against the model for the current inputs.
  task automatic settle();
    bit ev, act;
    logic [31:0] ei;
    #1;
    ev  = (exp_q.size() != 0);
    act = ev && !rst;
    ei  = ev ? exp_q[0][31:0] : I_ADD;
    chk("out_valid", 64'(out_valid0), 64'(ev));
    chk("out_valid_m", 64'(out_valid1), 64'(ev));
    chk("in_ready", 64'(in_ready0), 64'(!ev || out_ready));
    if (ev) chk("out_pc_instr", {out_pc0, out_instr0}, exp_q[0]);
    chk("bundle", 64'(b0), 64'(model_bundle(ei, 1'b0, act, br_eq, br_lt, br_ltu, intr)));
    chk("bundle_m", 64'(b1), 64'(model_bundle(ei, 1'b1, act, br_eq, br_lt, br_ltu, intr)));
  endtask

  // Apply the rising edge to the model, then move to the next falling edge.
  task automatic advance();
    bit rdy;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      rdy = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) exp_q.push_back({in_pc, in_instr});
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  initial begin
    logic [6:0] ops [11];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F};
    rst = 1'b1; br_eq = 0; br_lt = 0; br_ltu = 0; intr = 0;
    drive(1, I_ADD, 32'h100, 1, 0);
    @(negedge clk);

    // reset held with input offered
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_valid", 64'(out_valid0), 64'd0);
      chk("rst_reg_wr", 64'(reg_wr0), 64'd0);
      chk("rst_pcs", 64'(pcs0), 64'd0);
      chk("rst_instr", 64'(out_instr0), 64'(NOP_VAL()));
      advance();
    end
    rst = 1'b0;
    settle();
    chk("first_accept_pending", 64'(out_valid0), 64'd0);
    advance();

    // stream ADD, SUB, SRAI, then BGE
    drive(1, I_SUB, 32'h104, 1, 0);
    settle();
    chk("add_alu", 64'(alu_fun0), 64'h00);
    chk("add_wrsel", 64'(wrsel0), 64'd3);
    advance();
    drive(1, I_SRAI, 32'h108, 1, 0);
    settle();
    chk("sub_alu", 64'(alu_fun0), 64'h08);
    advance();
    drive(1, I_BGE, 32'h10C, 1, 0);
    settle();
    chk("srai_alu", 64'(alu_fun0), 64'h0D);
    chk("srai_wrsel", 64'(wrsel0), 64'd3);
    advance();

    // BGE held, flags change underneath
    drive(0, I_ADD, 32'h110, 0, 0);
    br_lt = 1;
    settle();
    chk("bge_lt1", 64'(pcs0), 64'd0);
    advance();
    br_lt = 0;
    settle();
    chk("bge_lt0", 64'(pcs0), 64'd2);
    advance();

    // backpressure with an instruction waiting
    drive(1, I_ADD, 32'h110, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_ready", 64'(in_ready0), 64'd0);
      chk("stall_instr", 64'(out_instr0), 64'(I_BGE));
      advance();
    end

    // flush drops both held and concurrent input
    drive(1, I_XOR, 32'h114, 1, 1);
    settle();
    advance();
    drive(0, I_ADD, 32'h118, 1, 0);
    settle();
    chk("flush_valid", 64'(out_valid0), 64'd0);
    advance();
    settle();
    chk("flush_dropped", 64'(out_valid0), 64'd0);
    advance();

    // MUL on the two configurations
    drive(1, I_MUL, 32'h200, 1, 0);
    settle();
    advance();
    drive(1, I_SW, 32'h204, 1, 0);
    settle();
    chk("mul_illegal", 64'(ill0), 64'd1);
    chk("mul_reg_wr", 64'(reg_wr0), 64'd0);
    chk("mul_pcs", 64'(pcs0), 64'd4);
    chk("mul_m_group", 64'(alu_fun1[4]), 64'd1);
    chk("mul_m_legal", 64'(ill1), 64'd0);
    advance();

    // interrupt over a held store, then MRET
    drive(0, I_ADD, 32'h208, 0, 0);
    intr = 1;
    settle();
    chk("intr_taken", 64'(it0), 64'd1);
    chk("intr_mem_wr", 64'(mem_wr0), 64'd0);
    chk("intr_pcs", 64'(pcs0), 64'd4);
    advance();
    intr = 0;
    settle();
    chk("sw_mem_wr", 64'(mem_wr0), 64'd1);
    advance();
    drive(1, I_MRET, 32'h208, 1, 0);
    settle();
    advance();
    drive(0, I_ADD, 32'h20C, 1, 0);
    settle();
    chk("mret", 64'(mret0), 64'd1);
    chk("mret_pcs", 64'(pcs0), 64'd5);
    advance();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:25] = 7'h01;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) ins = I_MRET;
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      br_eq  = $urandom_range(0, 1);
      br_lt  = $urandom_range(0, 1);
      br_ltu = $urandom_range(0, 1);
      intr   = ($urandom_range(0, 3) == 0);
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [31:0] NOP_VAL();
    return 32'h0000_0013;
  endfunction

endmodule
